// File: rtl/overcurrent_monitor_pkg.sv
// Shared definitions for the overcurrent monitor and the drive system that consumes it.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: channel state encoding, counter widths, trip-count saturation value.
package overcurrent_monitor_pkg;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_FILTER  = 2'd1,
        ST_TRIPPED = 2'd2,
        ST_LOCKOUT = 2'd3
    } ocState_e;

    localparam int FILTER_CNT_W = 8;   // FILTER_CYCLES up to 255
    localparam int HOLD_CNT_W   = 20;  // HOLD_CYCLES up to 2^20-1
    localparam int TRIP_CNT_W   = 4;   // trip count saturates at 15
    localparam int TRIP_SUM_W   = TRIP_CNT_W + 1;

    localparam logic [TRIP_CNT_W-1:0] TRIP_CNT_MAX = '1;

endpackage

// File: rtl/overcurrent_monitor_oc_channel.sv
// One overcurrent channel: 2-flop synchronizer, glitch filter, trip hold, retry lockout.
// Latency: over rises on the (FILTER_CYCLES+2)th edge after a sustained comparator rise.
// Backpressure: none; comparator is sampled every cycle.
// Ports: clk, nRst (sync, active-low), comp (raw async comparator), clear (releases lockout,
//        zeroes counts); over, tripCount (registered), lockNext (next-cycle LOCKOUT flag for Fault).
module oc_channel
    import overcurrent_monitor_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES   = 50000,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  comp,
    input  logic                  clear,
    output logic                  over,
    output logic [TRIP_CNT_W-1:0] tripCount,
    output logic                  lockNext
);

    // Comparisons use "last value" constants so the increment never needs an extra bit.
    localparam logic [FILTER_CNT_W-1:0] FILTER_LAST = FILTER_CNT_W'(FILTER_CYCLES - 1);
    localparam logic [HOLD_CNT_W-1:0]   HOLD_LAST   = HOLD_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [TRIP_SUM_W-1:0]   RETRY_LIMIT = TRIP_SUM_W'(MAX_RETRIES);

    logic                    syncMeta;
    logic                    syncOut;
    ocState_e                state,     stateNext;
    logic [FILTER_CNT_W-1:0] filterCnt, filterNext;
    logic [HOLD_CNT_W-1:0]   holdCnt,   holdNext;
    logic [TRIP_CNT_W-1:0]   tripCnt,   tripNext;
    logic [TRIP_SUM_W-1:0]   tripSum;
    logic                    tripEntry;
    logic                    overNext;

    always_ff @(posedge clk) begin
        if (!nRst) begin
            syncMeta  <= 1'b0;
            syncOut   <= 1'b0;
            state     <= ST_OK;
            filterCnt <= '0;
            holdCnt   <= '0;
            tripCnt   <= '0;
            over      <= 1'b0;
        end else begin
            syncMeta  <= comp;
            syncOut   <= syncMeta;
            state     <= stateNext;
            filterCnt <= filterNext;
            holdCnt   <= holdNext;
            tripCnt   <= tripNext;
            over      <= overNext;
        end
    end

    always_comb begin
        stateNext  = state;
        filterNext = filterCnt;
        holdNext   = holdCnt;
        tripNext   = tripCnt;
        tripEntry  = 1'b0;
        // Unsaturated sum decides lockout, so saturation at 15 can never mask a lockout.
        tripSum    = {1'b0, tripCnt} + 1'b1;

        case (state)
            ST_OK: begin
                filterNext = '0;
                if (syncOut) begin
                    // A one-sample filter trips straight out of OK.
                    if (FILTER_LAST == '0) begin
                        tripEntry = 1'b1;
                    end else begin
                        stateNext  = ST_FILTER;
                        filterNext = FILTER_CNT_W'(1);
                    end
                end
            end
            ST_FILTER: begin
                if (!syncOut) begin
                    stateNext  = ST_OK;
                    filterNext = '0;
                end else if (filterCnt >= FILTER_LAST) begin
                    tripEntry = 1'b1;
                end else begin
                    filterNext = filterCnt + 1'b1;
                end
            end
            ST_TRIPPED: begin
                if (holdCnt >= HOLD_LAST) begin
                    // Hold expired: release if the fault cleared, otherwise re-arm the hold.
                    holdNext = '0;
                    if (!syncOut) begin
                        stateNext = ST_OK;
                    end
                end else begin
                    holdNext = holdCnt + 1'b1;
                end
            end
            ST_LOCKOUT: begin
                stateNext = ST_LOCKOUT;
            end
            default: begin
                stateNext = ST_OK;
            end
        endcase

        if (tripEntry) begin
            filterNext = '0;
            holdNext   = '0;
            tripNext   = (tripCnt == TRIP_CNT_MAX) ? tripCnt : tripCnt + 1'b1;
            stateNext  = (tripSum > RETRY_LIMIT) ? ST_LOCKOUT : ST_TRIPPED;
        end

        // Clear overrides everything above, including a trip on the same edge.
        if (clear) begin
            stateNext  = ST_OK;
            filterNext = '0;
            holdNext   = '0;
            tripNext   = '0;
        end

        overNext = (stateNext == ST_TRIPPED) || (stateNext == ST_LOCKOUT);
        lockNext = (stateNext == ST_LOCKOUT);
    end

    assign tripCount = tripCnt;

endmodule

// File: rtl/overcurrent_monitor.sv
// Three-channel overcurrent monitor (motor A, motor B, battery) with shared fault flag.
// Latency: Over* rise FILTER_CYCLES+2 edges after a sustained comparator rise; Fault aligns with Over*.
// Backpressure: none.
// Ports: CLK, nRST (sync, active-low), CompA/CompB/CompBat (raw async), Clear;
//        OverA/OverB/OverBat, Fault, TripCountA/B/Bat (all registered).
module overcurrent_monitor
    import overcurrent_monitor_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES   = 50000,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  CompA,
    input  logic                  CompB,
    input  logic                  CompBat,
    input  logic                  Clear,
    output logic                  OverA,
    output logic                  OverB,
    output logic                  OverBat,
    output logic                  Fault,
    output logic [TRIP_CNT_W-1:0] TripCountA,
    output logic [TRIP_CNT_W-1:0] TripCountB,
    output logic [TRIP_CNT_W-1:0] TripCountBat
);

    logic lockNextA, lockNextB, lockNextBat;

    oc_channel #(.FILTER_CYCLES(FILTER_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .MAX_RETRIES(MAX_RETRIES)) uChanA (
        .clk(CLK), .nRst(nRST), .comp(CompA), .clear(Clear),
        .over(OverA), .tripCount(TripCountA), .lockNext(lockNextA)
    );

    oc_channel #(.FILTER_CYCLES(FILTER_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .MAX_RETRIES(MAX_RETRIES)) uChanB (
        .clk(CLK), .nRst(nRST), .comp(CompB), .clear(Clear),
        .over(OverB), .tripCount(TripCountB), .lockNext(lockNextB)
    );

    oc_channel #(.FILTER_CYCLES(FILTER_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .MAX_RETRIES(MAX_RETRIES)) uChanBat (
        .clk(CLK), .nRst(nRST), .comp(CompBat), .clear(Clear),
        .over(OverBat), .tripCount(TripCountBat), .lockNext(lockNextBat)
    );

    // Registered from the channels' next-state so Fault changes on the same edge as Over*.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            Fault <= 1'b0;
        end else begin
            Fault <= lockNextA | lockNextB | lockNextBat;
        end
    end

endmodule

// File: tb/tb_overcurrent_monitor.sv
module tb_overcurrent_monitor;

    localparam int F = 4;
    localparam int H = 10;
    localparam int M = 2;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       CompA = 1'b0, CompB = 1'b0, CompBat = 1'b0, Clear = 1'b0;
    logic       OverA, OverB, OverBat, Fault;
    logic [3:0] TripCountA, TripCountB, TripCountBat;

    int total = 0;
    int bad   = 0;

    overcurrent_monitor #(.FILTER_CYCLES(F), .HOLD_CYCLES(H), .MAX_RETRIES(M)) dut (
        .CLK(CLK), .nRST(nRST),
        .CompA(CompA), .CompB(CompB), .CompBat(CompBat), .Clear(Clear),
        .OverA(OverA), .OverB(OverB), .OverBat(OverBat), .Fault(Fault),
        .TripCountA(TripCountA), .TripCountB(TripCountB), .TripCountBat(TripCountBat)
    );

    always #5 CLK = ~CLK;

    // Reference model: per channel, the sample the logic sees lags the raw input by two
    // edges; a run of F seen-high samples while idle is a trip; a trip holds for H edges.
    bit pipe1[3], pipe2[3];
    int runLen[3], heldFor[3], trips[3];
    bit isTripped[3], isLocked[3];

    task automatic modelEdge();
        bit raw[3];
        bit seen;
        int n;
        raw[0] = CompA; raw[1] = CompB; raw[2] = CompBat;
        for (int c = 0; c < 3; c++) begin
            if (!nRST) begin
                pipe1[c] = 0; pipe2[c] = 0; runLen[c] = 0; heldFor[c] = 0;
                trips[c] = 0; isTripped[c] = 0; isLocked[c] = 0;
            end else begin
                seen = pipe2[c];
                pipe2[c] = pipe1[c];
                pipe1[c] = raw[c];
                if (Clear) begin
                    runLen[c] = 0; heldFor[c] = 0; trips[c] = 0;
                    isTripped[c] = 0; isLocked[c] = 0;
                end else if (isLocked[c]) begin
                    // stays latched
                end else if (isTripped[c]) begin
                    heldFor[c] = heldFor[c] + 1;
                    if (heldFor[c] == H) begin
                        heldFor[c] = 0;
                        if (!seen) isTripped[c] = 0;
                    end
                end else begin
                    runLen[c] = seen ? runLen[c] + 1 : 0;
                    if (runLen[c] == F) begin
                        runLen[c] = 0;
                        n = trips[c] + 1;
                        trips[c] = (n > 15) ? 15 : n;
                        if (n > M) isLocked[c] = 1;
                        else begin isTripped[c] = 1; heldFor[c] = 0; end
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        chk("overA",   OverA,   32'(isTripped[0] | isLocked[0]));
        chk("overB",   OverB,   32'(isTripped[1] | isLocked[1]));
        chk("overBat", OverBat, 32'(isTripped[2] | isLocked[2]));
        chk("fault",   Fault,   32'(isLocked[0] | isLocked[1] | isLocked[2]));
        chk("tripCntA",   TripCountA,   32'(trips[0]));
        chk("tripCntB",   TripCountB,   32'(trips[1]));
        chk("tripCntBat", TripCountBat, 32'(trips[2]));
    endtask

    task automatic tick();
        @(posedge CLK);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int hiCnt;
        bit bSeen;
        int left[3];
        bit lvl[3];

        // Reset state
        nRST = 1'b0;
        idle(2);
        chk("rst_overA", OverA, 0);
        chk("rst_fault", Fault, 0);
        chk("rst_tripCntA", TripCountA, 0);
        nRST = 1'b1;
        idle(3);

        // Sustained rise on A: Over on the 6th edge, not the 5th
        CompA = 1'b1;
        idle(5);
        chk("lat_overA_edge5", OverA, 0);
        tick();
        chk("lat_overA_edge6", OverA, 1);
        chk("lat_tripCntA", TripCountA, 1);
        chk("lat_overB", OverB, 0);
        chk("lat_overBat", OverBat, 0);

        // Held high through several hold periods: no extra trips
        idle(25);
        chk("hold_overA", OverA, 1);
        chk("hold_tripCntA", TripCountA, 1);
        CompA = 1'b0;
        idle(20);
        chk("release_overA", OverA, 0);

        // Interrupted B pulses never trip
        bSeen = 0;
        for (int i = 0; i < 17; i++) begin
            CompB = (i < 3 || (i >= 4 && i < 7)) ? 1'b1 : 1'b0;
            tick();
            bSeen |= OverB;
        end
        chk("glitch_overB_never", 32'(bSeen), 0);
        chk("glitch_tripCntB", TripCountB, 0);

        // 8-cycle pulse on A: Over high for exactly H cycles
        hiCnt = 0;
        for (int i = 0; i < 30; i++) begin
            CompA = (i < 8) ? 1'b1 : 1'b0;
            tick();
            if (OverA === 1'b1) hiCnt++;
        end
        chk("pulse_overA_len", 32'(hiCnt), 32'(H));
        chk("pulse_tripCntA", TripCountA, 2);

        Clear = 1'b1; tick(); Clear = 1'b0;
        chk("clr_tripCntA", TripCountA, 0);

        // Three battery trips: third one locks out
        for (int t = 0; t < 3; t++) begin
            CompBat = 1'b1; idle(6);
            CompBat = 1'b0; idle(16);
        end
        chk("lock_fault", Fault, 1);
        chk("lock_overBat", OverBat, 1);
        chk("lock_tripCntBat", TripCountBat, 3);
        idle(20);
        chk("lock_hold_overBat", OverBat, 1);
        Clear = 1'b1; tick(); Clear = 1'b0;
        chk("unlock_overBat", OverBat, 0);
        chk("unlock_fault", Fault, 0);
        chk("unlock_tripCntBat", TripCountBat, 0);

        // Reset during TRIPPED
        CompA = 1'b1; idle(7);
        chk("pre_rst_overA", OverA, 1);
        nRST = 1'b0; Clear = 1'b1; tick();
        chk("rst_trip_overA", OverA, 0);
        chk("rst_trip_cntA", TripCountA, 0);
        nRST = 1'b1; Clear = 1'b0; CompA = 1'b0;
        idle(3);

        // Clear on the same edge as a trip entry
        CompA = 1'b1; idle(5);
        Clear = 1'b1; tick(); Clear = 1'b0;
        chk("clr_race_overA", OverA, 0);
        chk("clr_race_cntA", TripCountA, 0);
        CompA = 1'b0;
        idle(5);

        // Randomized phase against the model
        for (int c = 0; c < 3; c++) begin left[c] = 0; lvl[c] = 0; end
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 3; c++) begin
                if (left[c] == 0) begin
                    lvl[c] = ~lvl[c];
                    left[c] = lvl[c] ? int'($urandom_range(1, 14)) : int'($urandom_range(1, 18));
                end
                left[c]--;
            end
            CompA = lvl[0]; CompB = lvl[1]; CompBat = lvl[2];
            Clear = ($urandom_range(0, 149) == 0);
            nRST  = ($urandom_range(0, 499) != 0);
            tick();
        end
        nRST = 1'b1; Clear = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/overcurrent_monitor.md
OVERCURRENT_MONITOR -- requirements
Module: overcurrent_monitor

Interface
REQ-001 Parameter FILTER_CYCLES, default 16, consecutive synchronized high samples required to declare a trip (range 1..255).
REQ-002 Parameter HOLD_CYCLES, default 50000, minimum cycles a trip indication is held (range 1..2^20-1).
REQ-003 Parameter MAX_RETRIES, default 3, trips allowed per channel before lockout (range 1..15).
REQ-004 CLK  input  1  sole clock, rising-edge.
REQ-005 nRST  input  1  reset, synchronous, active-low.
REQ-006 CompA, CompB, CompBat  input  1 each  raw asynchronous current-sense comparator outputs, high = overcurrent on motor A, motor B, battery.
REQ-007 Clear  input  1  synchronous, active-high; releases lockout and zeroes trip counts on all channels.
REQ-008 OverA, OverB, OverBat  output  1 each  registered trip indications, high = overcurrent; feed the drive system's Over inputs.
REQ-009 Fault  output  1  registered; high while any channel is in LOCKOUT.
REQ-010 TripCountA, TripCountB, TripCountBat  output  4 each  registered trip counts per channel.

Function
REQ-011 Each Comp input SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Three identical independent channels SHALL run the FSM OK, FILTER, TRIPPED, LOCKOUT.
REQ-013 OK: filter counter 0, Over low; synchronized input high -> FILTER with counter 1.
REQ-014 FILTER: synchronized high increments counter; synchronized low -> OK, counter 0; counter reaching FILTER_CYCLES -> trip entry.
REQ-015 Trip entry: trip count +1; if new count <= MAX_RETRIES -> TRIPPED with hold counter 0, else -> LOCKOUT; Over registered high in the same edge.
REQ-016 Latency: raw input held high continuously SHALL assert Over on exactly the (FILTER_CYCLES+2)th rising edge after the rise; a single low sample before then restarts the filter.
REQ-017 TRIPPED: Over high; hold counter increments each cycle; at HOLD_CYCLES, synchronized low -> OK (Over low next edge), synchronized high -> hold counter restarts at 0, remain TRIPPED, no additional trip counted.
REQ-018 LOCKOUT: Over high, Fault high, state held regardless of Comp until Clear.
REQ-019 Clear SHALL force all channels to OK, trip counts 0, filter/hold counters 0, Over and Fault low on the next edge; Clear wins over a simultaneous trip entry; filtering restarts from the first sample after Clear deasserts.
REQ-020 Trip count SHALL saturate at 15; never wraps.
REQ-021 Channels SHALL not interact; simultaneous trips on all three are each handled independently.
REQ-022 Fault SHALL be the registered OR of the three LOCKOUT states.

Reset
REQ-023 nRST low at a rising edge SHALL set all channels to OK, synchronizers to 0, all counters to 0, Over*, Fault low, TripCount* 0 on that edge.
REQ-024 Reset asserted mid-FILTER, mid-TRIPPED or in LOCKOUT SHALL discard that state entirely; nRST dominates Clear.

Structure
REQ-025 State encoding constants (OK, FILTER, TRIPPED, LOCKOUT) and counter widths SHALL live in a shared package used by the drive system.
REQ-026 One sub-module oc_channel (synchronizer, FSM, counters) SHALL be instantiated three times; the top adds only Fault and wiring.

Verification (FILTER_CYCLES=4, HOLD_CYCLES=10, MAX_RETRIES=2)
REQ-027 CompA high continuously from edge 0 -> OverA high at edge 6, TripCountA=1, OverB/OverBat low.
REQ-028 CompB high 3 cycles, low 1, high 3 -> OverB never asserts, TripCountB stays 0.
REQ-029 CompA 8-cycle pulse -> OverA high for exactly 10 cycles then low; CompA held high instead -> OverA stays high, TripCountA stays 1.
REQ-030 Three separate CompBat trips -> third trip enters LOCKOUT, Fault high, TripCountBat=3; OverBat stays high with CompBat low until Clear, then OverBat, Fault low, TripCountBat=0 one edge later.
REQ-031 nRST low during TRIPPED and Clear asserted on the same edge as a trip entry -> outputs 0 next edge in both cases, no trip counted.
